// File: rtl/hpdcache_pkg.sv
// Shared directory types and arbiter mode selection for the HPDcache directory path.
package hpdcache_pkg;

  typedef enum logic {
    ARB_RR   = 1'b0,
    ARB_PRIO = 1'b1
  } hpdcache_dir_arb_mode_e;

  localparam int unsigned HPDCACHE_DIR_WAYS    = 4;
  localparam int unsigned HPDCACHE_DIR_ADDR_W  = 8;
  localparam int unsigned HPDCACHE_DIR_ENTRY_W = 8;

  typedef logic [HPDCACHE_DIR_ADDR_W-1:0]  dir_addr_t;
  typedef logic [HPDCACHE_DIR_WAYS-1:0]    way_vector_t;
  typedef logic [HPDCACHE_DIR_ENTRY_W-1:0] dir_entry_t;

  // One directory command as seen by the directory controller.
  typedef struct packed {
    dir_addr_t                           addr;
    way_vector_t                         cs;
    way_vector_t                         we;
    dir_entry_t [HPDCACHE_DIR_WAYS-1:0]  wentry;
  } dir_req_t;

endpackage

// File: rtl/hpdcache_dir_arb_age.sv
// Saturating wait counter for one requester; flags the requester as starving at MaxStall.
module hpdcache_dir_arb_age #(
  parameter int unsigned MaxStall = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid,
  input  logic grant,
  input  logic stall,
  output logic starving
);

  localparam int unsigned AgeW = $clog2(MaxStall + 1);

  logic [AgeW-1:0] age_q;

  // Count cycles spent waiting; a stalled directory does not age anyone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_q <= '0;
    end else if (!valid || grant) begin
      age_q <= '0;
    end else if (!stall && (age_q != AgeW'(MaxStall))) begin
      age_q <= age_q + AgeW'(1);
    end
  end

  assign starving = valid && (age_q == AgeW'(MaxStall));

endmodule

// File: rtl/hpdcache_dir_access_arb.sv
// N-requester arbiter in front of the directory SRAM: one command per cycle,
// per-requester read-response strobe one cycle after a granted read.
module hpdcache_dir_access_arb
  import hpdcache_pkg::*;
#(
  parameter int unsigned            NumReq   = 2,
  parameter int unsigned            NumWays  = 4,
  parameter hpdcache_dir_arb_mode_e ArbMode  = ARB_RR,
  parameter int unsigned            MaxStall = 8,
  parameter type hpdcache_dir_addr_t   = dir_addr_t,
  parameter type hpdcache_way_vector_t = logic [NumWays-1:0],
  parameter type hpdcache_dir_entry_t  = dir_entry_t
) (
  input  logic                                           clk_i,
  input  logic                                           rst_ni,
  input  logic                 [NumReq-1:0]              req_valid_i,
  output logic                 [NumReq-1:0]              req_ready_o,
  input  hpdcache_dir_addr_t   [NumReq-1:0]              req_addr_i,
  input  hpdcache_way_vector_t [NumReq-1:0]              req_cs_i,
  input  hpdcache_way_vector_t [NumReq-1:0]              req_we_i,
  input  hpdcache_dir_entry_t  [NumReq-1:0][NumWays-1:0] req_wentry_i,
  input  logic                                           dir_stall_i,
  output hpdcache_dir_addr_t                             dir_addr_o,
  output hpdcache_way_vector_t                           dir_cs_o,
  output hpdcache_way_vector_t                           dir_we_o,
  output hpdcache_dir_entry_t  [NumWays-1:0]             dir_wentry_o,
  output logic                 [NumReq-1:0]              rsp_valid_o,
  output logic                                           starve_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [IdxW-1:0]   ptr_q;
  logic [IdxW-1:0]   winner;
  logic [NumReq-1:0] starving;
  logic [NumReq-1:0] rsp_valid_q;
  logic              grant_en;
  logic              is_read;

  // Age counters exist only in fixed-priority mode; round-robin cannot starve.
  if (ArbMode == ARB_PRIO) begin : g_age
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
      hpdcache_dir_arb_age #(
        .MaxStall(MaxStall)
      ) u_age (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .valid    (req_valid_i[gi]),
        .grant    (req_ready_o[gi]),
        .stall    (dir_stall_i),
        .starving (starving[gi])
      );
    end
  end else begin : g_no_age
    assign starving = '0;
  end

  // Pick the winner: round-robin from ptr_q, or lowest starving else highest valid index.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    if (ArbMode == ARB_RR) begin
      for (int k = int'(NumReq) - 1; k >= 0; k--) begin
        idx = int'(ptr_q) + k;
        if (idx >= int'(NumReq)) idx = idx - int'(NumReq);
        if (req_valid_i[IdxW'(idx)]) winner = IdxW'(idx);
      end
    end else begin
      for (int k = 0; k < int'(NumReq); k++) begin
        if (req_valid_i[IdxW'(k)]) winner = IdxW'(k);
      end
      if (|starving) begin
        for (int k = int'(NumReq) - 1; k >= 0; k--) begin
          if (starving[IdxW'(k)]) winner = IdxW'(k);
        end
      end
    end
  end

  // Grant and SRAM command; strobes are gated off when idle, stalled or in reset.
  always_comb begin
    grant_en     = rst_ni & ~dir_stall_i & (|req_valid_i);
    req_ready_o  = grant_en ? (NumReq'(1) << winner) : '0;
    dir_addr_o   = req_addr_i[winner];
    dir_wentry_o = req_wentry_i[winner];
    dir_cs_o     = grant_en ? req_cs_i[winner] : '0;
    dir_we_o     = grant_en ? req_we_i[winner] : '0;
    is_read      = |(req_cs_i[winner] & ~req_we_i[winner]);
    starve_o     = grant_en & starving[winner];
  end

  // Round-robin pointer moves just past the requester that was served.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if ((ArbMode == ARB_RR) && grant_en) begin
      ptr_q <= (winner == IdxW'(NumReq - 1)) ? '0 : winner + IdxW'(1);
    end
  end

  // Tag the next cycle's SRAM read data with the requester that issued the read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= '0;
    end else begin
      rsp_valid_q <= req_ready_o & {NumReq{is_read}};
    end
  end

  assign rsp_valid_o = rsp_valid_q;

  // Requesters must keep a pending request and its payload stable until granted.
  for (genvar gi = 0; gi < NumReq; gi++) begin : g_chk
    assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_valid_i[gi] && !req_ready_o[gi]) |=>
        (req_valid_i[gi] && $stable(req_addr_i[gi]) && $stable(req_cs_i[gi]) &&
         $stable(req_we_i[gi]) && $stable(req_wentry_i[gi])));
    assert property (@(posedge clk_i) disable iff (!rst_ni)
      req_valid_i[gi] |-> (req_cs_i[gi] != '0));
  end

endmodule

// File: tb/tb_hpdcache_dir_access_arb.sv
// Scoreboard bench: one round-robin (3 requesters) and one fixed-priority (2 requesters,
// MaxStall=4) instance, directed vectors with hand-computed grants and responses.
module tb_hpdcache_dir_access_arb;
  import hpdcache_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic stall;

  // Round-robin instance signals
  logic [2:0]            a_valid, a_ready, a_rsp;
  logic [2:0][7:0]       a_addr;
  logic [2:0][3:0]       a_cs, a_we;
  logic [2:0][3:0][7:0]  a_wentry;
  logic [7:0]            a_dir_addr;
  logic [3:0]            a_dir_cs, a_dir_we;
  logic [3:0][7:0]       a_dir_wentry;
  logic                  a_starve;

  // Fixed-priority instance signals
  logic [1:0]            b_valid, b_ready, b_rsp;
  logic [1:0][7:0]       b_addr;
  logic [1:0][3:0]       b_cs, b_we;
  logic [1:0][3:0][7:0]  b_wentry;
  logic [7:0]            b_dir_addr;
  logic [3:0]            b_dir_cs, b_dir_we;
  logic [3:0][7:0]       b_dir_wentry;
  logic                  b_starve;

  typedef struct {
    logic [2:0]  ready;
    logic [7:0]  addr;
    logic [3:0]  cs;
    logic [3:0]  we;
    logic [31:0] went;
    logic        starve;
  } gnt_t;

  gnt_t       a_gq[$], b_gq[$];
  logic [2:0] a_rq[$], b_rq[$];
  gnt_t       ea, eb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hpdcache_dir_access_arb #(
    .NumReq(3), .NumWays(4), .ArbMode(ARB_RR), .MaxStall(8),
    .hpdcache_dir_addr_t(logic [7:0]), .hpdcache_way_vector_t(logic [3:0]),
    .hpdcache_dir_entry_t(logic [7:0])
  ) u_dut_rr (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(a_valid), .req_ready_o(a_ready),
    .req_addr_i(a_addr), .req_cs_i(a_cs), .req_we_i(a_we), .req_wentry_i(a_wentry),
    .dir_stall_i(stall), .dir_addr_o(a_dir_addr), .dir_cs_o(a_dir_cs), .dir_we_o(a_dir_we),
    .dir_wentry_o(a_dir_wentry), .rsp_valid_o(a_rsp), .starve_o(a_starve)
  );

  hpdcache_dir_access_arb #(
    .NumReq(2), .NumWays(4), .ArbMode(ARB_PRIO), .MaxStall(4),
    .hpdcache_dir_addr_t(logic [7:0]), .hpdcache_way_vector_t(logic [3:0]),
    .hpdcache_dir_entry_t(logic [7:0])
  ) u_dut_prio (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(b_valid), .req_ready_o(b_ready),
    .req_addr_i(b_addr), .req_cs_i(b_cs), .req_we_i(b_we), .req_wentry_i(b_wentry),
    .dir_stall_i(stall), .dir_addr_o(b_dir_addr), .dir_cs_o(b_dir_cs), .dir_we_o(b_dir_we),
    .dir_wentry_o(b_dir_wentry), .rsp_valid_o(b_rsp), .starve_o(b_starve)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Expected grant (and response, when the request reads) for a round-robin requester.
  function automatic void exp_a(int i, bit rsp_ok);
    gnt_t e;
    e.ready  = 3'(1 << i);
    e.addr   = a_addr[i];
    e.cs     = a_cs[i];
    e.we     = a_we[i];
    e.went   = a_wentry[i];
    e.starve = 1'b0;
    a_gq.push_back(e);
    if (rsp_ok && ((a_cs[i] & ~a_we[i]) != 4'b0)) a_rq.push_back(3'(1 << i));
  endfunction

  // Expected grant for a fixed-priority requester, with the forced-grant flag.
  function automatic void exp_b(int i, bit starve);
    gnt_t e;
    e.ready  = 3'(1 << i);
    e.addr   = b_addr[i];
    e.cs     = b_cs[i];
    e.we     = b_we[i];
    e.went   = b_wentry[i];
    e.starve = starve;
    b_gq.push_back(e);
    if ((b_cs[i] & ~b_we[i]) != 4'b0) b_rq.push_back(3'(1 << i));
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: sample away from the active edge and compare against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("a_reset_outputs", {a_ready, a_dir_cs, a_dir_we, a_rsp, a_starve}, 32'h0);
      check("b_reset_outputs", {b_ready, b_dir_cs, b_dir_we, b_rsp, b_starve}, 32'h0);
    end else begin
      if (a_ready != 3'b0) begin
        $display("%0t rr   grant %b addr %h cs %b we %b", $time, a_ready, a_dir_addr, a_dir_cs, a_dir_we);
        if (a_gq.size() == 0) check("a_unexpected_grant", {29'b0, a_ready}, 32'h0);
        else begin
          ea = a_gq.pop_front();
          check("a_ready", {29'b0, a_ready}, {29'b0, ea.ready});
          check("a_addr", {24'b0, a_dir_addr}, {24'b0, ea.addr});
          check("a_cs_we", {24'b0, a_dir_cs, a_dir_we}, {24'b0, ea.cs, ea.we});
          check("a_wentry", a_dir_wentry, ea.went);
          check("a_starve", {31'b0, a_starve}, {31'b0, ea.starve});
        end
      end else begin
        check("a_idle_cs_we_starve", {23'b0, a_dir_cs, a_dir_we, a_starve}, 32'h0);
      end
      if (a_rsp != 3'b0) begin
        $display("%0t rr   rsp   %b", $time, a_rsp);
        if (a_rq.size() == 0) check("a_unexpected_rsp", {29'b0, a_rsp}, 32'h0);
        else check("a_rsp", {29'b0, a_rsp}, {29'b0, a_rq.pop_front()});
      end
      if (b_ready != 2'b0) begin
        $display("%0t prio grant %b addr %h cs %b we %b starve %b", $time, b_ready, b_dir_addr, b_dir_cs, b_dir_we, b_starve);
        if (b_gq.size() == 0) check("b_unexpected_grant", {30'b0, b_ready}, 32'h0);
        else begin
          eb = b_gq.pop_front();
          check("b_ready", {29'b0, 1'b0, b_ready}, {29'b0, eb.ready});
          check("b_addr", {24'b0, b_dir_addr}, {24'b0, eb.addr});
          check("b_cs_we", {24'b0, b_dir_cs, b_dir_we}, {24'b0, eb.cs, eb.we});
          check("b_wentry", b_dir_wentry, eb.went);
          check("b_starve", {31'b0, b_starve}, {31'b0, eb.starve});
        end
      end else begin
        check("b_idle_cs_we_starve", {23'b0, b_dir_cs, b_dir_we, b_starve}, 32'h0);
      end
      if (b_rsp != 2'b0) begin
        $display("%0t prio rsp   %b", $time, b_rsp);
        if (b_rq.size() == 0) check("b_unexpected_rsp", {30'b0, b_rsp}, 32'h0);
        else check("b_rsp", {29'b0, 1'b0, b_rsp}, {29'b0, b_rq.pop_front()});
      end
    end
  end

  initial begin
    rst_n   = 1'b1;
    stall   = 1'b0;
    a_valid = '0;
    b_valid = '0;
    for (int i = 0; i < 3; i++) begin
      a_addr[i]   = 8'(8'hA0 + i);
      a_wentry[i] = 32'h11223344 + 32'(i);
    end
    a_cs[0] = 4'b0001; a_we[0] = 4'b0000;   // read
    a_cs[1] = 4'b0010; a_we[1] = 4'b0010;   // write
    a_cs[2] = 4'b0100; a_we[2] = 4'b0000;   // read
    for (int i = 0; i < 2; i++) begin
      b_addr[i]   = 8'(8'h50 + i);
      b_wentry[i] = 32'hC0DE0000 + 32'(i);
    end
    b_cs[0] = 4'b0001; b_we[0] = 4'b0000;   // read
    b_cs[1] = 4'b1000; b_we[1] = 4'b1000;   // write

    // Reset: requests present but nothing may be granted
    #2 rst_n = 1'b0;
    a_valid = 3'b111;
    b_valid = 2'b11;
    repeat (2) cyc();
    a_valid = '0;
    b_valid = '0;
    cyc();
    rst_n = 1'b1;

    // Round-robin, all valid: 0,1,2,0,1,2 then drain 0,1
    for (int c = 0; c < 8; c++) begin
      cyc();
      a_valid = (c < 6) ? 3'b111 : ((c == 6) ? 3'b011 : 3'b010);
      exp_a(c % 3, 1'b1);
    end
    cyc();
    a_valid = '0;

    // Fixed priority with aging: req1 wins 4 times, req0 forced on the 5th cycle
    for (int c = 0; c < 6; c++) begin
      cyc();
      b_valid = (c < 5) ? 2'b11 : 2'b10;
      exp_b((c == 4) ? 0 : 1, c == 4);
    end
    cyc();
    b_valid = '0;

    // Three stalled cycles: no grants, ages frozen; normal service resumes on release
    cyc();
    stall   = 1'b1;
    a_valid = 3'b001;
    b_valid = 2'b11;
    repeat (2) cyc();
    for (int c = 0; c < 6; c++) begin
      cyc();
      if (c == 0) begin
        stall = 1'b0;
        exp_a(0, 1'b1);
      end else begin
        a_valid = '0;
      end
      b_valid = (c < 5) ? 2'b11 : 2'b10;
      exp_b((c == 4) ? 0 : 1, c == 4);
    end
    cyc();
    b_valid = '0;

    // Read with cs=0010 gives one response; pure write cs=we=0001 gives none
    cyc();
    a_cs[1] = 4'b0010; a_we[1] = 4'b0000;
    a_valid = 3'b010;
    exp_a(1, 1'b1);
    cyc();
    a_cs[0] = 4'b0001; a_we[0] = 4'b0001;
    a_valid = 3'b001;
    exp_a(0, 1'b1);
    cyc();
    a_valid = '0;

    // Reset while a read response is pending: response dropped, pointer back to 0
    cyc();
    a_valid = 3'b010;
    exp_a(1, 1'b0);
    cyc();
    a_valid = '0;
    rst_n   = 1'b0;
    #1 check("a_rsp_dropped_on_reset", {29'b0, a_rsp}, 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    a_valid = 3'b111;
    exp_a(0, 1'b1);
    cyc();
    a_valid = 3'b110;
    exp_a(1, 1'b1);
    cyc();
    a_valid = 3'b100;
    exp_a(2, 1'b1);
    cyc();
    a_valid = '0;

    repeat (3) cyc();
    check("a_grants_outstanding", a_gq.size(), 32'h0);
    check("a_rsps_outstanding", a_rq.size(), 32'h0);
    check("b_grants_outstanding", b_gq.size(), 32'h0);
    check("b_rsps_outstanding", b_rq.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
